// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter that sits in front of the SRAM wrapper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN
  } arb_state_t;

  typedef enum logic {
    GNT_M0,
    GNT_M1
  } gnt_t;

  // Width of the GRANT-cycle timeout counter; bounds TIMEOUT_CYCLES to 255.
  localparam int CNT_W = 8;

  // The master that is not g; used for round-robin tie breaking.
  function automatic gnt_t other_gnt(input gnt_t g);
    return (g == GNT_M0) ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a sole requester always wins, and a tie
// goes to whichever master did not win last time.
module rr_pick2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  gnt_t       last_gnt_i,
  output gnt_t       gnt_o,
  output logic       valid_o
);

  // Pick the winner; gnt_o is only meaningful when valid_o is high.
  always_comb begin
    valid_o = |req_i;
    gnt_o   = GNT_M0;
    if (req_i == 2'b11) begin
      gnt_o = other_gnt(last_gnt_i);
    end else if (req_i[1]) begin
      gnt_o = GNT_M1;
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter merging instruction fetch (m0) and data (m1) onto the
// single SRAM slave port. One single-beat transfer is granted at a time, every grant is
// followed by at least one non-GRANT cycle, and a silent slave is answered with err.
module wb_sram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  // Counter value in the last GRANT cycle that may still see an ack before err fires.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  gnt_t             gnt_q, gnt_d;
  gnt_t             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;

  logic [1:0]       req;
  gnt_t             pick_gnt;
  logic             pick_valid;

  logic             mux_cyc;
  logic             mux_we;
  logic [31:0]      mux_adr;
  logic [31:0]      mux_dat;
  logic [3:0]       mux_sel;

  logic             in_grant;
  logic             ack_hit;
  logic             abort_hit;
  logic             timeout_hit;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_pick2 u_pick (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick_gnt),
    .valid_o    (pick_valid)
  );

  // Select the bus signals of the currently granted master.
  always_comb begin
    mux_cyc = m0_cyc_i;
    mux_we  = m0_we_i;
    mux_adr = m0_adr_i;
    mux_dat = m0_dat_i;
    mux_sel = m0_sel_i;
    if (gnt_q == GNT_M1) begin
      mux_cyc = m1_cyc_i;
      mux_we  = m1_we_i;
      mux_adr = m1_adr_i;
      mux_dat = m1_dat_i;
      mux_sel = m1_sel_i;
    end
  end

  // Classify the current GRANT cycle; ack beats abort, and abort beats timeout.
  always_comb begin
    in_grant    = (state_q == ST_GRANT);
    ack_hit     = in_grant & s_ack_i;
    abort_hit   = in_grant & ~s_ack_i & ~mux_cyc;
    timeout_hit = in_grant & ~s_ack_i & mux_cyc & (cnt_q == TIMEOUT_LAST);
  end

  // Next-state logic: arbitration in IDLE, completion/abort/timeout in GRANT, one dead cycle in DRAIN.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_GRANT;
          gnt_d      = pick_gnt;
          last_gnt_d = pick_gnt;
          cnt_d      = '0;
        end
      end
      ST_GRANT: begin
        adr_d = mux_adr;
        dat_d = mux_dat;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ack_hit) begin
          state_d = ST_IDLE;
        end else if (abort_hit || timeout_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, timeout counter and held slave address/data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_M0;
      last_gnt_q <= GNT_M1;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  // Slave side: live mux during GRANT, idle strobes and held address/data otherwise.
  always_comb begin
    s_cyc_o = in_grant;
    s_stb_o = in_grant;
    s_we_o  = in_grant & mux_we;
    s_sel_o = in_grant ? mux_sel : 4'b0000;
    s_adr_o = in_grant ? mux_adr : adr_q;
    s_dat_o = in_grant ? mux_dat : dat_q;
  end

  // Master side: read data is broadcast, ack/err steered only to the granted master.
  always_comb begin
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = ack_hit & (gnt_q == GNT_M0);
    m1_ack_o = ack_hit & (gnt_q == GNT_M1);
    m0_err_o = timeout_hit & (gnt_q == GNT_M0);
    m1_err_o = timeout_hit & (gnt_q == GNT_M1);
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Scoreboard bench for wb_sram_arbiter: directed master traffic against a small
// registered-ack SRAM slave model; expected ack/err events are queued with their cycle.
module tb_wb_sram_arbiter;

  typedef struct {
    bit          master;
    bit          is_err;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic        slave_en;
  int          cyc_n;
  int          tests_run;
  int          fail_cnt;
  exp_t        sb[$];

  wb_sram_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Cycle counter used to timestamp expected and observed responses.
  initial cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  // SRAM wrapper model: registered ack one cycle after it sees a strobe; slave_en=0 makes it mute.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) s_ack_i <= 1'b0;
    else       s_ack_i <= slave_en & s_stb_o & ~s_ack_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic applyStimulus(input bit m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (!m) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic pushExp(input bit master, input bit is_err, input logic [31:0] data, input int cycle);
    exp_t e;
    e.master = master;
    e.is_err = is_err;
    e.data   = data;
    e.cycle  = cycle;
    sb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkIdleBus(input string name);
    checkOutput({name, "_cyc"}, 32'(s_cyc_o), 32'd0);
    checkOutput({name, "_stb"}, 32'(s_stb_o), 32'd0);
    checkOutput({name, "_sel"}, 32'(s_sel_o), 32'd0);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    @(negedge clk_i);
    checkIdleBus("rst");
    checkOutput("rst_we", 32'(s_we_o), 32'd0);
    checkOutput("rst_adr", s_adr_o, 32'd0);
    checkOutput("rst_dat", s_dat_o, 32'd0);
    checkOutput("rst_ack_err", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
    nextCycle();
    rst_i = 1'b0;
  endtask

  // Monitor: whenever any master sees ack or err, pop the oldest expectation and compare.
  always @(negedge clk_i) begin
    if (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) begin
      checkOutput("resp_onehot", 32'($countones({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o})), 32'd1);
      if (sb.size() == 0) begin
        tests_run++;
        fail_cnt++;
        $display("[TB] FAIL resp_unexpected: got ack/err %b%b%b%b, expected none (cycle %0d)",
                 m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, cyc_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resp_master", 32'(m1_ack_o | m1_err_o), 32'(e.master));
        checkOutput("resp_is_err", 32'(m0_err_o | m1_err_o), 32'(e.is_err));
        checkOutput("resp_cycle", 32'(cyc_n), 32'(e.cycle));
        if (!e.is_err) begin
          checkOutput("resp_data", e.master ? m1_dat_o : m0_dat_o, e.data);
        end
      end
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios: single read, round-robin contention, timeout, abort, async reset.
  initial begin
    int c0;
    tests_run = 0;
    fail_cnt  = 0;
    slave_en  = 1'b1;
    s_dat_i   = 32'h0;
    rst_i     = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    doReset();

    // m0 read alone: stb in cycle 1, ack with data in cycle 2.
    nextCycle();
    c0 = cyc_n;
    s_dat_i = 32'hDEADBEEF;
    applyStimulus(0, 1, 1, 0, 32'h40, 32'h0, 4'hF);
    pushExp(0, 0, 32'hDEADBEEF, c0 + 2);
    nextCycle();
    @(negedge clk_i);
    checkOutput("t1_stb", 32'(s_stb_o), 32'd1);
    checkOutput("t1_adr", s_adr_o, 32'h40);
    checkOutput("t1_sel", 32'(s_sel_o), 32'hF);
    checkOutput("t1_we", 32'(s_we_o), 32'd0);
    nextCycle();
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h40, 32'h0, 4'hF);
    @(negedge clk_i);
    checkIdleBus("t1_idle");
    checkOutput("t1_adr_hold", s_adr_o, 32'h40);

    // Both masters contend: alternating grants m0,m1,m0,m1 with acks 3 cycles apart.
    nextCycle();
    doReset();
    nextCycle();
    c0 = cyc_n;
    s_dat_i = 32'h12345678;
    applyStimulus(0, 1, 1, 0, 32'h40, 32'h0, 4'hF);
    applyStimulus(1, 1, 1, 1, 32'h100, 32'hCAFE0001, 4'b0011);
    for (int i = 0; i < 4; i++) pushExp(i[0], 0, 32'h12345678, c0 + 2 + 3 * i);
    for (int k = 1; k <= 11; k++) begin
      nextCycle();
      @(negedge clk_i);
      if (k % 3 == 0) begin
        checkIdleBus("t2_idle");
        checkOutput("t2_adr_hold", s_adr_o, (((k / 3) % 2) == 1) ? 32'h40 : 32'h100);
      end else begin
        checkOutput("t2_stb", 32'(s_stb_o), 32'd1);
        if (((k - 1) / 3) % 2 == 0) begin
          checkOutput("t2_m0_sel", 32'(s_sel_o), 32'hF);
          checkOutput("t2_m0_we", 32'(s_we_o), 32'd0);
          checkOutput("t2_m0_adr", s_adr_o, 32'h40);
        end else begin
          checkOutput("t2_m1_sel", 32'(s_sel_o), 32'b0011);
          checkOutput("t2_m1_we", 32'(s_we_o), 32'd1);
          checkOutput("t2_m1_adr", s_adr_o, 32'h100);
          checkOutput("t2_m1_dat", s_dat_o, 32'hCAFE0001);
        end
      end
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Mute slave: m1 gets exactly one err in its 15th GRANT cycle, then DRAIN and IDLE.
    slave_en = 1'b0;
    nextCycle();
    c0 = cyc_n;
    applyStimulus(1, 1, 1, 0, 32'h200, 32'h0, 4'b1100);
    pushExp(1, 1, 32'h0, c0 + 15);
    for (int k = 1; k <= 15; k++) begin
      nextCycle();
      @(negedge clk_i);
      checkOutput("t3_stb_grant", 32'(s_stb_o), 32'd1);
    end
    nextCycle();
    applyStimulus(1, 0, 0, 0, 32'h200, 32'h0, 4'b1100);
    @(negedge clk_i);
    checkIdleBus("t3_drain");
    nextCycle();
    @(negedge clk_i);
    checkIdleBus("t3_idle");

    // m0 aborts in its first GRANT cycle; the stale ack lands in DRAIN, then m1 is served.
    slave_en = 1'b1;
    nextCycle();
    c0 = cyc_n;
    s_dat_i = 32'hA5A50004;
    applyStimulus(0, 1, 1, 0, 32'h300, 32'h0, 4'hF);
    applyStimulus(1, 1, 1, 0, 32'h104, 32'h0, 4'b0011);
    pushExp(1, 0, 32'hA5A50004, c0 + 5);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h300, 32'h0, 4'hF);
    @(negedge clk_i);
    checkOutput("t4_m0_grant_adr", s_adr_o, 32'h300);
    nextCycle();
    @(negedge clk_i);
    checkIdleBus("t4_drain");
    nextCycle();
    @(negedge clk_i);
    checkIdleBus("t4_idle");
    nextCycle();
    @(negedge clk_i);
    checkOutput("t4_m1_stb", 32'(s_stb_o), 32'd1);
    checkOutput("t4_m1_adr", s_adr_o, 32'h104);
    checkOutput("t4_m1_sel", 32'(s_sel_o), 32'b0011);
    nextCycle();
    nextCycle();
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Async reset mid-GRANT: strobe falls before the next edge; afterwards a tie goes to m0.
    nextCycle();
    applyStimulus(1, 1, 1, 0, 32'h108, 32'h0, 4'hF);
    nextCycle();
    checkOutput("t5_stb_before", 32'(s_stb_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("t5_async_stb", 32'(s_stb_o), 32'd0);
    checkOutput("t5_async_cyc", 32'(s_cyc_o), 32'd0);
    @(negedge clk_i);
    checkOutput("t5_rst_ack_err", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    c0 = cyc_n;
    s_dat_i = 32'h0BADF00D;
    applyStimulus(0, 1, 1, 0, 32'h44, 32'h0, 4'hF);
    pushExp(0, 0, 32'h0BADF00D, c0 + 2);
    nextCycle();
    @(negedge clk_i);
    checkOutput("t5_tie_m0_adr", s_adr_o, 32'h44);
    checkOutput("t5_tie_m0_sel", 32'(s_sel_o), 32'hF);
    nextCycle();
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    @(negedge clk_i);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
